// File: rtl/da_fir4_if.sv
// da_fir4_if: operand/result bundle between the sample loader, the DA engine and the LMS update stage
interface da_fir4_if #(parameter int DW = 8, parameter int WW = 8, parameter int OW = DW + WW + 2);
  logic start, busy, done;
  logic signed [DW-1:0] x0, x1, x2, x3;
  logic signed [WW-1:0] w0, w1, w2, w3;
  logic signed [OW-1:0] y;
  modport master (output start, x0, x1, x2, x3, w0, w1, w2, w3, input busy, done, y);
  modport slave (input start, x0, x1, x2, x3, w0, w1, w2, w3, output busy, done, y);
endinterface

// File: rtl/da_fir4_bitserial.sv
// da_fir4_bitserial: 4-tap distributed-arithmetic inner product, one sample bit-slice per clock
module da_fir4_bitserial #(parameter int DW = 8, parameter int WW = 8, parameter int OW = DW + WW + 2) (
  input logic clk,
  input logic rst,
  da_fir4_if.slave b
);
  localparam int KW = $clog2(DW);
  typedef enum logic {IDLE, RUN} state_t;
  state_t st;
  logic signed [DW-1:0] xs [4];
  logic signed [WW-1:0] ws [4];
  logic signed [OW-1:0] acc, term, nxt;
  logic signed [WW+1:0] lut [16];
  logic [KW-1:0] k;
  logic [3:0] addr;
  logic last;
  always_comb begin
    for (int a = 0; a < 16; a++) begin
      lut[a] = '0;
      for (int i = 0; i < 4; i++)
        if (a[i]) lut[a] = lut[a] + (WW+2)'(ws[i]);
    end
  end
  assign addr = {xs[3][k], xs[2][k], xs[1][k], xs[0][k]};
  assign last = k == KW'(DW - 1);
  assign term = OW'(lut[addr]) << k;
  // the top slice carries negative weight in two's complement
  assign nxt = last ? acc - term : acc + term;
  always_ff @(posedge clk) begin
    if (!rst) begin
      st <= IDLE;
      b.busy <= 1'b0;
      b.done <= 1'b0;
      b.y <= '0;
      acc <= '0;
      k <= '0;
      for (int i = 0; i < 4; i++) begin
        xs[i] <= '0;
        ws[i] <= '0;
      end
    end else begin
      b.done <= 1'b0;
      if (st == IDLE) begin
        if (b.start) begin
          xs[0] <= b.x0;
          xs[1] <= b.x1;
          xs[2] <= b.x2;
          xs[3] <= b.x3;
          ws[0] <= b.w0;
          ws[1] <= b.w1;
          ws[2] <= b.w2;
          ws[3] <= b.w3;
          acc <= '0;
          k <= '0;
          b.busy <= 1'b1;
          st <= RUN;
        end
      end else begin
        acc <= nxt;
        k <= k + KW'(1);
        if (last) begin
          b.y <= nxt;
          b.done <= 1'b1;
          b.busy <= 1'b0;
          k <= '0;
          st <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_da_fir4_bitserial.sv
// tb_da_fir4_bitserial: dot-product reference model with per-cycle output compare plus directed vectors
module tb_da_fir4_bitserial;
  localparam int DW = 8, WW = 8, OW = DW + WW + 2;
  logic clk = 0, rst = 0;
  int errors = 0, checks = 0;
  int m_cnt = 0, m_res = 0, m_y = 0;
  bit m_done = 0, live = 0;
  da_fir4_if #(.DW(DW), .WW(WW), .OW(OW)) ifc ();
  da_fir4_bitserial #(.DW(DW), .WW(WW), .OW(OW)) dut (.clk(clk), .rst(rst), .b(ifc.slave));
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // a start accepted in idle yields the plain dot product DW edges later
  always @(posedge clk) begin
    m_done = 0;
    if (!rst) begin
      m_cnt = 0;
      m_y = 0;
      live = 1;
    end else if (m_cnt == 0) begin
      if (ifc.start) begin
        m_res = int'(ifc.x0) * int'(ifc.w0) + int'(ifc.x1) * int'(ifc.w1)
              + int'(ifc.x2) * int'(ifc.w2) + int'(ifc.x3) * int'(ifc.w3);
        m_cnt = DW;
      end
    end else begin
      m_cnt--;
      if (m_cnt == 0) begin
        m_y = m_res;
        m_done = 1;
      end
    end
  end

  always @(negedge clk) if (live) begin
    chk("busy", int'(ifc.busy), int'(m_cnt != 0));
    chk("done", int'(ifc.done), int'(m_done));
    chk("y", int'(ifc.y), m_y);
  end

  task automatic setop(input int a0, a1, a2, a3, c0, c1, c2, c3);
    ifc.x0 = DW'(a0); ifc.x1 = DW'(a1); ifc.x2 = DW'(a2); ifc.x3 = DW'(a3);
    ifc.w0 = WW'(c0); ifc.w1 = WW'(c1); ifc.w2 = WW'(c2); ifc.w3 = WW'(c3);
  endtask

  task automatic wait_done(input string name, output int n);
    n = 0;
    while (!ifc.done && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!ifc.done) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic run(input string name, input int a0, a1, a2, a3, c0, c1, c2, c3, input int exp);
    int n;
    @(negedge clk);
    setop(a0, a1, a2, a3, c0, c1, c2, c3);
    ifc.start = 1;
    @(negedge clk);
    ifc.start = 0;
    wait_done(name, n);
    chk({name, "_lat"}, n, DW);
    chk({name, "_y"}, int'(ifc.y), exp);
    chk({name, "_model"}, m_y, exp);
  endtask

  initial begin
    int n;
    ifc.start = 0;
    setop(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("idle_y", int'(ifc.y), 0);
    chk("idle_busy", int'(ifc.busy), 0);
    run("basic", 1, 2, 3, 4, 1, 1, 1, 1, 10);
    run("sign", -128, 0, 0, 0, -128, 0, 0, 0, 16384);
    run("neg1", -1, -1, -1, -1, 3, -5, 7, -2, -3);
    run("ext_pos", -128, -128, -128, -128, 127, 127, 127, 127, -65024);
    run("ext_neg", -128, -128, -128, -128, -128, -128, -128, -128, 65536);
    // start re-asserted and operands scrambled while running
    @(negedge clk);
    setop(10, -20, 30, -40, 2, 3, 4, 5);
    ifc.start = 1;
    @(negedge clk);
    ifc.start = 0;
    @(negedge clk);
    ifc.start = 1;
    setop(99, 99, 99, 99, -7, -7, -7, -7);
    repeat (3) @(negedge clk);
    ifc.start = 0;
    setop(-1, 5, -9, 3, 11, 0, 1, 2);
    wait_done("midrun", n);
    chk("midrun_y", int'(ifc.y), -120);
    repeat (12) @(negedge clk);
    // reset lands on the edge that would process slice 4
    setop(7, 7, 7, 7, 7, 7, 7, 7);
    ifc.start = 1;
    @(negedge clk);
    ifc.start = 0;
    repeat (4) @(negedge clk);
    rst = 0;
    @(negedge clk);
    chk("abort_busy", int'(ifc.busy), 0);
    chk("abort_y", int'(ifc.y), 0);
    rst = 1;
    repeat (12) @(negedge clk);
    // back-to-back with start held high
    setop(1, 2, 3, 4, 5, 6, 7, 8);
    ifc.start = 1;
    @(negedge clk);
    wait_done("b2b1", n);
    chk("b2b1_y", int'(ifc.y), 70);
    setop(-3, 0, 5, -7, 2, 9, -4, 1);
    @(negedge clk);
    wait_done("b2b2", n);
    ifc.start = 0;
    chk("b2b_gap", n + 1, DW + 1);
    chk("b2b2_y", int'(ifc.y), -33);
    repeat (12) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/da_fir4_bitserial.md
Name: da_fir4_bitserial

Overview:
- Distributed-arithmetic (DA) 4-tap inner-product engine.
- Sits directly downstream of the 4-sample input loader in the DA-based LMS adaptive filter.
- Consumes the parallel samples x0..x3 and the current tap weights w0..w3, and computes y = x0*w0 + x1*w1 + x2*w2 + x3*w3 bit-serially, one input bit-slice per clock.
- The LMS error/weight-update stage consumes y.

Parameters:
- DW, 8, sample width (signed two's complement).
- WW, 8, weight width (signed two's complement).
- OW, DW+WW+2, output width; sized to hold the worst-case 4-term sum.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset (rst=0 resets on the clock edge).
- start  input  1  request to compute; sampled only in IDLE.
- x0,x1,x2,x3  input  DW each, signed  tap samples; latched when start is accepted.
- w0,w1,w2,w3  input  WW each, signed  tap weights; latched when start is accepted.
- busy  output  1  high while a computation is in progress.
- done  output  1  one-cycle pulse when y is updated.
- y  output  OW, signed  result; holds its value until the next done.

Behaviour:
- One clock. Reset is synchronous and active-low (rst=0 sampled on the clk rising edge).
- Reset values: state=IDLE, busy=0, done=0, y=0. All internal sample, weight and accumulator registers are 0, and the bit index k is 0.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
- IDLE -> RUN, on the edge where start=1:
  - latch xs_i <= x_i and ws_i <= w_i;
  - acc <= 0, k <= 0, busy <= 1.
- Start while in RUN is ignored. The latched operands are unaffected by input changes during RUN.
- LUT:
  - 16 entries derived combinationally from the latched weights.
  - L[a] = sum of ws_i for every bit i set in a, where a = {b3,b2,b1,b0}.
  - Entries are sign-extended to WW+2 bits.
- RUN, one slice per edge for k = 0..DW-1:
  - address a = {xs3[k], xs2[k], xs1[k], xs0[k]};
  - for k < DW-1: acc <= acc + (sext(L[a]) << k);
  - for k = DW-1 (the sign slice): acc <= acc - (sext(L[a]) << k).
- All arithmetic is done at OW bits, signed. There is no overflow for any in-range operands.
- On the edge that processes k = DW-1:
  - y <= the final accumulator value (including that slice);
  - done <= 1, busy <= 0, state <= IDLE.
- Latency: start is accepted at edge E0; y and done are valid after edge E(DW), i.e. E8 by default. Throughput is one result per DW+1 cycles.
- done is high for exactly one cycle. It is 0 in all other cycles.
- Back-to-back operation: start held high in the cycle where done=1 is accepted at the next edge, and a new RUN begins.
- Reset mid-RUN aborts the computation: the outputs return to their reset values, and no done pulse is produced for the aborted operation.
- Reset takes priority over start on the same edge.

Test Plan:
- Reset then idle: rst=0 for 2 cycles, then rst=1 with start=0 -> busy=0, done=0, y=0 held.
- Basic: x=(1,2,3,4), w=(1,1,1,1), start for 1 cycle -> busy=1 for 8 cycles; done pulses exactly 8 cycles after acceptance with y=10.
- Sign handling: x0=-128, w0=-128, others 0 -> y=16384. Then x=(-1,-1,-1,-1), w=(3,-5,7,-2) -> y=-3.
- Extremes: all x=-128 with all w=127 -> y=-65024. All x=-128 with all w=-128 -> y=65536, with no overflow at OW=18.
- Start during busy, and input changes in RUN: re-assert start and toggle x/w mid-RUN -> result is unchanged (y computed from the latched operands); only one done pulse occurs.
- Reset mid-RUN, then back-to-back:
  - rst=0 at slice k=4 -> busy=0, y=0, no done.
  - Then two computations with start held high continuously -> two done pulses 9 cycles apart with the correct y for each.
